// File: rtl/plot_sequencer.sv
// Column scheduler: waits for the parser, then for each column evaluates y(x), maps it to a row
// and writes one pixel. Out-of-range or failed evaluations skip the pixel but still advance the column.
module plot_sequencer #(
   parameter int                      NUMBER_WIDTH          = 16,
   parameter int                      FRACTIONAL_PART_WIDTH = 8,
   parameter int                      SCREEN_WIDTH          = 640,
   parameter int                      SCREEN_HEIGHT         = 480,
   parameter int                      Y_CENTER              = 240,
   parameter logic [NUMBER_WIDTH-1:0] X_MIN                 = 16'hB000,
   parameter logic [NUMBER_WIDTH-1:0] X_STEP                = 16'h0040,
   localparam int                     XW                    = $clog2(SCREEN_WIDTH),
   localparam int                     YW                    = $clog2(SCREEN_HEIGHT)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    parser_ready,
   output logic                    eval_start,
   output logic [NUMBER_WIDTH-1:0] eval_x,
   input  logic                    eval_done,
   input  logic [NUMBER_WIDTH-1:0] eval_y,
   input  logic                    eval_error,
   output logic                    pixel_valid,
   output logic [XW-1:0]           pixel_x,
   output logic [YW-1:0]           pixel_y,
   input  logic                    pixel_ready,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [2:0] {
      IDLE, WAIT_PARSER, ISSUE_EVAL, WAIT_EVAL, MAP_ROW, WRITE_PIXEL, NEXT_COL
   } state_t;

   localparam logic signed [NUMBER_WIDTH+1:0] ROW_CENTER = (NUMBER_WIDTH+2)'(Y_CENTER);
   localparam logic signed [NUMBER_WIDTH+1:0] ROW_LIMIT  = (NUMBER_WIDTH+2)'(SCREEN_HEIGHT);
   localparam logic [XW-1:0]                  LAST_COL   = XW'(SCREEN_WIDTH - 1);

   state_t                   state, state_nxt;
   logic [XW-1:0]            col;
   logic [NUMBER_WIDTH-1:0]  y_q;
   logic                     err_q;
   logic signed [NUMBER_WIDTH+1:0] y_ext, yi, row;
   logic                     row_ok;

   // Two guard bits keep Y_CENTER - floor(y) from wrapping for any input y.
   assign y_ext  = {{2{y_q[NUMBER_WIDTH-1]}}, y_q};
   assign yi     = y_ext >>> FRACTIONAL_PART_WIDTH;
   assign row    = ROW_CENTER - yi;
   assign row_ok = !err_q && !row[NUMBER_WIDTH+1] && (row < ROW_LIMIT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      eval_start  = 1'b0;
      pixel_valid = 1'b0;
      done        = 1'b0;
      busy        = (state != IDLE);
      case (state)
         IDLE:        if (start) state_nxt = WAIT_PARSER;
         WAIT_PARSER: if (parser_ready) state_nxt = ISSUE_EVAL;
         ISSUE_EVAL: begin
            eval_start = 1'b1;
            state_nxt  = WAIT_EVAL;
         end
         WAIT_EVAL:   if (eval_done) state_nxt = MAP_ROW;
         MAP_ROW:     state_nxt = row_ok ? WRITE_PIXEL : NEXT_COL;
         WRITE_PIXEL: begin
            pixel_valid = 1'b1;
            if (pixel_ready) state_nxt = NEXT_COL;
         end
         NEXT_COL: begin
            if (col == LAST_COL) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else begin
               state_nxt = ISSUE_EVAL;
            end
         end
         default:     state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col     <= '0;
         eval_x  <= '0;
         y_q     <= '0;
         err_q   <= 1'b0;
         pixel_x <= '0;
         pixel_y <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               col    <= '0;
               eval_x <= X_MIN;
            end
            WAIT_EVAL: if (eval_done) begin
               y_q   <= eval_y;
               err_q <= eval_error;
            end
            MAP_ROW: if (row_ok) begin
               pixel_x <= col;
               pixel_y <= row[YW-1:0];
            end
            NEXT_COL: if (col != LAST_COL) begin
               col    <= col + XW'(1);
               eval_x <= eval_x + X_STEP;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_plot_sequencer.sv
// Scoreboard bench for plot_sequencer on a 4x8 screen with a 3-cycle evaluator model.
module tb_plot_sequencer;
   localparam int NW = 16;

   logic          clk = 1'b0;
   logic          rst_n, start, parser_ready, eval_done, eval_error, pixel_ready;
   logic [NW-1:0] eval_y;
   logic          eval_start, pixel_valid, busy, done;
   logic [NW-1:0] eval_x;
   logic [1:0]    pixel_x;
   logic [2:0]    pixel_y;

   plot_sequencer #(
      .NUMBER_WIDTH(16), .FRACTIONAL_PART_WIDTH(8), .SCREEN_WIDTH(4), .SCREEN_HEIGHT(8),
      .Y_CENTER(4), .X_MIN(16'hFE00), .X_STEP(16'h0100)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .parser_ready(parser_ready),
      .eval_start(eval_start), .eval_x(eval_x), .eval_done(eval_done), .eval_y(eval_y),
      .eval_error(eval_error), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .pixel_ready(pixel_ready), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;
   logic [NW-1:0] exp_x_q[$];
   logic [4:0]    exp_pix_q[$];
   int            done_cnt = 0;
   bit            slow_ready = 0, use_tab = 0;
   int            stray_req = 0, stray_seen = 0;
   logic [NW-1:0] tab_y[4];
   bit            tab_err[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Evaluator model: y = x (or table entry per column), 3 cycles after eval_start.
   int            lat = 0;
   logic [NW-1:0] cur_x;
   always @(negedge clk) begin
      if (!rst_n) begin
         lat = 0; eval_done = 0; eval_error = 0; eval_y = '0;
      end else begin
         eval_done = 0; eval_error = 0;
         if (stray_req != stray_seen) begin
            stray_seen = stray_req;
            eval_done = 1; eval_y = 16'h7FFF; eval_error = 1;
         end else if (eval_start) begin
            cur_x = eval_x;
            lat = 3;
            chk("no_pixel_during_eval_start", {31'd0, pixel_valid}, 32'd0);
            if (exp_x_q.size() == 0) chk("unexpected_eval_start", eval_x, 32'hFFFF_FFFF);
            else chk("eval_x", eval_x, exp_x_q.pop_front());
         end else if (lat > 0) begin
            lat--;
            if (lat == 0) begin
               logic [NW-1:0] idx;
               idx = (cur_x - 16'hFE00) >> 8;
               eval_done = 1;
               if (use_tab) begin
                  eval_y = tab_y[idx[1:0]]; eval_error = tab_err[idx[1:0]];
               end else begin
                  eval_y = cur_x;
               end
            end
         end
      end
   end

   // Pixel sink and monitor: drives pixel_ready, pops the pixel scoreboard on each transfer.
   int         vcnt = 0;
   logic [4:0] held;
   always @(negedge clk) begin
      if (!rst_n) begin
         vcnt = 0; pixel_ready = 0;
      end else begin
         if (pixel_valid) begin
            vcnt++;
            if (vcnt == 1) held = {pixel_x, pixel_y};
            else chk("pixel_hold", {27'd0, pixel_x, pixel_y}, {27'd0, held});
         end else begin
            vcnt = 0;
         end
         pixel_ready = slow_ready ? (vcnt >= 4) : 1'b1;
         if (pixel_valid && pixel_ready) begin
            if (slow_ready) chk("valid_len", vcnt, 4);
            if (exp_pix_q.size() == 0) chk("unexpected_pixel", {27'd0, pixel_x, pixel_y}, 32'hFFFF_FFFF);
            else chk("pixel_xy", {27'd0, pixel_x, pixel_y}, {27'd0, exp_pix_q.pop_front()});
         end
         if (done) done_cnt++;
      end
   end

   task automatic push_run(input bit only_first);
      exp_x_q.push_back(16'hFE00); exp_x_q.push_back(16'hFF00);
      exp_x_q.push_back(16'h0000); exp_x_q.push_back(16'h0100);
      exp_pix_q.push_back({2'd0, 3'd6});
      if (!only_first) begin
         exp_pix_q.push_back({2'd1, 3'd5});
         exp_pix_q.push_back({2'd2, 3'd4});
         exp_pix_q.push_back({2'd3, 3'd3});
      end
   endtask

   task automatic pulse_start();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
   endtask

   task automatic wait_done(input string name);
      int base = done_cnt;
      int i = 0;
      while (done_cnt == base && i < 500) begin
         @(negedge clk); #1;
         i++;
      end
      if (done_cnt == base) chk({name, "_timeout"}, 0, 1);
      repeat (3) @(negedge clk);
      #1;
      chk({name, "_done_pulses"}, done_cnt - base, 1);
      chk({name, "_busy_after"}, {31'd0, busy}, 0);
      chk({name, "_eval_q_empty"}, exp_x_q.size(), 0);
      chk({name, "_pix_q_empty"}, exp_pix_q.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string name);
      chk({name, "_busy"}, {31'd0, busy}, 0);
      chk({name, "_eval_start"}, {31'd0, eval_start}, 0);
      chk({name, "_pixel_valid"}, {31'd0, pixel_valid}, 0);
      chk({name, "_done"}, {31'd0, done}, 0);
      chk({name, "_eval_x"}, {16'd0, eval_x}, 0);
      chk({name, "_pixel_xy"}, {27'd0, pixel_x, pixel_y}, 0);
   endtask

   initial begin
      rst_n = 0; start = 0; parser_ready = 0;
      #2;
      chk_reset_outputs("reset");
      repeat (2) @(negedge clk);
      rst_n = 1;

      // 1: basic run
      parser_ready = 1;
      push_run(0);
      pulse_start();
      wait_done("t1");

      // 2: parser not ready for 10 cycles
      parser_ready = 0;
      push_run(0);
      pulse_start();
      repeat (10) @(negedge clk);
      #1;
      chk("t2_busy_waiting", {31'd0, busy}, 1);
      chk("t2_no_eval_yet", exp_x_q.size(), 4);
      parser_ready = 1;
      wait_done("t2");

      // 3: error, row -1 and row 8 are skipped
      tab_y[0] = 16'hFE00; tab_err[0] = 0;
      tab_y[1] = 16'hFF00; tab_err[1] = 1;
      tab_y[2] = 16'h0500; tab_err[2] = 0;
      tab_y[3] = 16'hFC80; tab_err[3] = 0;
      use_tab = 1;
      push_run(1);
      pulse_start();
      wait_done("t3");
      use_tab = 0;

      // 4: framebuffer backpressure
      slow_ready = 1;
      push_run(0);
      pulse_start();
      wait_done("t4");
      slow_ready = 0;

      // 5: stray eval_done while waiting for the parser, start while busy
      parser_ready = 0;
      push_run(0);
      pulse_start();
      repeat (2) @(negedge clk);
      stray_req++;
      repeat (3) @(negedge clk);
      parser_ready = 1;
      repeat (6) @(negedge clk);
      start = 1;
      @(negedge clk);
      start = 0;
      wait_done("t5");

      // 6: reset during WAIT_EVAL of column 2, then replay
      push_run(0);
      pulse_start();
      for (int i = 0; i < 300 && exp_x_q.size() > 1; i++) begin
         @(negedge clk); #1;
      end
      chk("t6_reached_col2", exp_x_q.size(), 1);
      @(negedge clk);
      #2;
      rst_n = 0;
      #1;
      chk_reset_outputs("t6_reset");
      exp_x_q.delete();
      exp_pix_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      push_run(0);
      pulse_start();
      wait_done("t6");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
